// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register, req/ack instruction fetch and next-PC redirect for the decoder
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 32
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic               imem_ack,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instr,
   output logic [5:0]         opcode,
   output logic               instr_valid,
   output logic [IMEM_AW-1:0] pc,
   output logic [IMEM_AW-1:0] pc_plus4,
   input  logic               consume,
   input  logic               branch_taken,
   input  logic [31:0]        branch_offset,
   input  logic               jump,
   input  logic [25:0]        jump_index
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   logic [1:0]         state;
   logic [IMEM_AW-1:0] fetch_pc;
   logic [IMEM_AW-1:0] next_pc;
   assign imem_req  = state == S_REQ;
   assign imem_addr = fetch_pc;
   assign opcode    = instr[31:26];
   assign pc_plus4  = pc + 32'd4;
   // jump keeps the upper nibble of the sequential PC and outranks any branch
   assign next_pc = jump ? {pc_plus4[31:28], jump_index, 2'b00} :
                    branch_taken ? pc_plus4 + (branch_offset << 2) : pc_plus4;
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc          <= RESET_PC;
      end else if (state == S_IDLE) begin
         state <= S_REQ;
      end else if (state == S_REQ) begin
         if (imem_ack) begin
            instr       <= imem_rdata;
            pc          <= fetch_pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
         end
      end else if (consume) begin
         fetch_pc    <= next_pc;
         instr_valid <= 1'b0;
         state       <= S_REQ;
      end
   end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the main control decoder. It holds the program counter, fetches instruction words over a req/ack instruction-memory interface, and presents the instruction word plus its opcode field (instr[31:26]) to the decoder. Next-PC selection (sequential, branch, jump) is applied from redirect inputs, which are driven by the Branch/Zero and Jump results of the current instruction.

Parameters:
RESET_PC, 32'h0000_0000, address of first fetch after reset; bits [1:0] must be 0
IMEM_AW, 32, PC / instruction-memory address width; fixed at 32 for MIPS jump formation

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request, held high until imem_ack
imem_addr  output  32  word-aligned fetch address, valid while imem_req=1
imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  32  fetched instruction word
instr  output  32  current instruction word (registered)
opcode  output  6  instr[31:26], drives the decoder opcode input
instr_valid  output  1  instr/opcode/pc/pc_plus4 hold a valid instruction
pc  output  32  address of the current instruction
pc_plus4  output  32  pc + 4 (combinational from pc)
consume  input  1  downstream retires the current instruction this cycle
branch_taken  input  1  Branch & Zero for the current instruction
branch_offset  input  32  sign-extended 16-bit immediate, not yet shifted
jump  input  1  Jump for the current instruction
jump_index  input  26  instr[25:0] target index

Behaviour:
- States: S_IDLE, S_REQ, S_HOLD. Encoding is free; state is not visible on ports.
- Reset (synchronous, wins over all other inputs in the same cycle):
  - state<=S_IDLE; fetch_pc<=RESET_PC; instr<=0; instr_valid<=0; pc<=RESET_PC.
  - imem_req=0 while in S_IDLE.
- S_IDLE:
  - imem_req=0.
  - Unconditionally go to S_REQ next cycle. This guarantees one dead cycle after reset.
- S_REQ:
  - imem_req=1; imem_addr=fetch_pc; instr_valid=0.
  - On imem_ack: instr<=imem_rdata; pc<=fetch_pc; instr_valid<=1; go to S_HOLD.
  - Without ack: stay; imem_addr held stable.
  - Ack may arrive in the same cycle as the first req, so best-case latency is req cycle to instr_valid on the next cycle.
- S_HOLD:
  - imem_req=0; instr_valid=1; instr, pc, opcode held stable.
  - When consume=1, compute next_pc:
    - jump=1: {pc_plus4[31:28], jump_index, 2'b00}. Jump has priority over branch.
    - else branch_taken=1: pc_plus4 + (branch_offset << 2), modulo 2^32.
    - else: pc_plus4.
  - On consume: fetch_pc<=next_pc; instr_valid<=0; go to S_REQ.
  - When consume=0: hold indefinitely, ignoring jump and branch_taken.
- Redirect inputs are sampled only in S_HOLD with consume=1. Values at any other time are don't-care.
- imem_ack outside S_REQ is ignored and must not change any state.
- Peak throughput: one instruction per 2 cycles (REQ with same-cycle ack, then HOLD with consume).
- PC arithmetic wraps modulo 2^32:
  - 32'hFFFF_FFFC + 4 = 0.
  - Negative offsets subtract.
  - imem_addr[1:0] is always 00.
- Reset mid-operation (S_REQ waiting, or S_HOLD): the in-flight request is abandoned and the flow returns to S_IDLE with fetch_pc=RESET_PC. An ack arriving in the cycle after reset is ignored because the block is in S_IDLE.
- opcode is always instr[31:26]. It reads 6'b000000 after reset, which the decoder treats as R-type; consumers must qualify with instr_valid.

Test Plan:
- Reset, zero-wait memory returning 32'h8C01_0004 at 0 -> imem_req rises 2nd cycle after reset, addr=0; next cycle instr_valid=1, opcode=6'b100011, pc=0, pc_plus4=4.
- Sequential: consume every HOLD, no redirects -> addresses 0,4,8,C; an instruction every 2 cycles.
- Branch: at pc=8, branch_taken=1, offset=32'hFFFF_FFFE with consume -> next imem_addr=4; offset=3 -> next imem_addr=24 (0x18).
- Jump priority: at pc=32'h1000_0010, jump=1, jump_index=26'h0000040, branch_taken=1 -> next imem_addr=32'h1000_0100.
- Backpressure/latency: consume=0 for 5 cycles with imem_ack delayed 3 cycles and stray acks in S_HOLD -> instr/pc stable, no req in S_HOLD, stray acks ignored.
- Reset while S_REQ waiting (addr=0x40) then late ack next cycle -> instr_valid=0, ack ignored, refetch from RESET_PC after the idle cycle.
